// File: rtl/axi4_burst_regbank.sv
// AXI4 burst slave fronting a word-addressed register bank.
// Independent write and read FSMs, one outstanding transaction per direction.
module axi4_burst_regbank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEPTH      = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned LANE_LOG = $clog2(STRB_W);
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [63:0] BANK_BYTES = 64'(DEPTH) * 64'(STRB_W);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_DATA = 1'b1;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, span, bound, inc;
    step  = ADDR_WIDTH'(1) << size;
    span  = step * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
    bound = addr & ~(span - ADDR_WIDTH'(1));
    // INCR beats after the first are size-aligned even from an unaligned start
    inc   = (addr & ~(step - ADDR_WIDTH'(1))) + step;
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = inc;
      BURST_WRAP: next_addr = (inc == bound + span) ? bound : inc;
      default:    next_addr = addr;
    endcase
  endfunction

  function automatic logic burst_bad(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = len inside {8'd1, 8'd3, 8'd7, 8'd15};
    burst_bad = (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok) ||
                (32'(size) > LANE_LOG);
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    in_range = (addr >= BASE_ADDR) && (64'(off) < BANK_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    word_idx = off[LANE_LOG +: IDX_W];
  endfunction

  // Lanes from the beat address up to the end of its size-aligned block
  function automatic logic [STRB_W-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] addr,
                                                  input logic [2:0] size);
    int unsigned lo;
    lo = 32'(addr[LANE_LOG-1:0]);
    for (int unsigned i = 0; i < STRB_W; i++) begin
      lane_mask[i] = (i >= lo) && ((i >> size) == (lo >> size));
    end
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write channel
  logic [1:0]            w_state_q;
  logic                  aw_ready_q, w_ready_q, b_valid_q;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q, w_cnt_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q, w_resp_q;
  logic                  w_bad_q;

  logic                  w_inr, w_last_beat;
  logic [STRB_W-1:0]     w_mask;
  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            w_beat_code, w_resp_d;

  always_comb begin
    w_inr       = in_range(w_addr_q);
    w_mask      = lane_mask(w_addr_q, w_size_q);
    w_idx       = word_idx(w_addr_q);
    w_last_beat = (w_cnt_q == w_len_q);
    if (!w_inr) begin
      w_beat_code = RESP_DECERR;
    end else if (w_bad_q || (WLAST != w_last_beat)) begin
      w_beat_code = RESP_SLVERR;
    end else begin
      w_beat_code = RESP_OKAY;
    end
    w_resp_d = (w_beat_code > w_resp_q) ? w_beat_code : w_resp_q;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_cnt_q    <= '0;
      w_size_q   <= '0;
      w_burst_q  <= '0;
      w_resp_q   <= RESP_OKAY;
      w_bad_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          aw_ready_q <= 1'b1;
          if (aw_ready_q && AWVALID) begin
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_id_q     <= AWID;
            w_addr_q   <= AWADDR;
            w_len_q    <= AWLEN;
            w_size_q   <= AWSIZE;
            w_burst_q  <= AWBURST;
            w_bad_q    <= burst_bad(AWSIZE, AWLEN, AWBURST);
            w_cnt_q    <= '0;
            w_resp_q   <= RESP_OKAY;
            w_state_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            if (w_inr && !w_bad_q) begin
              for (int i = 0; i < int'(STRB_W); i++) begin
                if (WSTRB[i] && w_mask[i]) mem[w_idx][8*i +: 8] <= WDATA[8*i +: 8];
              end
            end
            w_addr_q <= next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
            w_cnt_q  <= w_cnt_q + 8'd1;
            w_resp_q <= w_resp_d;
            if (w_last_beat) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_state_q  <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign AWREADY = aw_ready_q;
  assign WREADY  = w_ready_q;
  assign BVALID  = b_valid_q;
  assign BID     = w_id_q;
  assign BRESP   = w_resp_q;

  // Read channel
  logic                  r_state_q;
  logic                  ar_ready_q, r_valid_q, r_last_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q, r_cnt_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_burst_q, r_resp_q;
  logic                  r_bad_q;
  logic [DATA_WIDTH-1:0] r_data_q;

  // Beat about to be presented: AR fields in idle, the running burst otherwise
  logic [ADDR_WIDTH-1:0] r_sel_addr;
  logic                  r_sel_bad, r_sel_inr;
  logic [DATA_WIDTH-1:0] r_sel_data;
  logic [1:0]            r_sel_resp;

  always_comb begin
    r_sel_addr = (r_state_q == R_IDLE) ? ARADDR : r_addr_q;
    r_sel_bad  = (r_state_q == R_IDLE) ? burst_bad(ARSIZE, ARLEN, ARBURST) : r_bad_q;
    r_sel_inr  = in_range(r_sel_addr);
    r_sel_data = (r_sel_inr && !r_sel_bad) ? mem[word_idx(r_sel_addr)] : '0;
    if (!r_sel_inr) begin
      r_sel_resp = RESP_DECERR;
    end else if (r_sel_bad) begin
      r_sel_resp = RESP_SLVERR;
    end else begin
      r_sel_resp = RESP_OKAY;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_cnt_q    <= '0;
      r_size_q   <= '0;
      r_burst_q  <= '0;
      r_resp_q   <= RESP_OKAY;
      r_bad_q    <= 1'b0;
      r_data_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          ar_ready_q <= 1'b1;
          if (ar_ready_q && ARVALID) begin
            ar_ready_q <= 1'b0;
            r_id_q     <= ARID;
            r_len_q    <= ARLEN;
            r_size_q   <= ARSIZE;
            r_burst_q  <= ARBURST;
            r_bad_q    <= r_sel_bad;
            r_addr_q   <= next_addr(ARADDR, ARSIZE, ARLEN, ARBURST);
            r_cnt_q    <= '0;
            r_valid_q  <= 1'b1;
            r_data_q   <= r_sel_data;
            r_resp_q   <= r_sel_resp;
            r_last_q   <= (ARLEN == 8'd0);
            r_state_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (r_last_q) begin
              r_valid_q  <= 1'b0;
              r_last_q   <= 1'b0;
              ar_ready_q <= 1'b1;
              r_state_q  <= R_IDLE;
            end else begin
              r_data_q <= r_sel_data;
              r_resp_q <= r_sel_resp;
              r_last_q <= ((r_cnt_q + 8'd1) == r_len_q);
              r_cnt_q  <= r_cnt_q + 8'd1;
              r_addr_q <= next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign ARREADY = ar_ready_q;
  assign RVALID  = r_valid_q;
  assign RID     = r_id_q;
  assign RDATA   = r_data_q;
  assign RRESP   = r_resp_q;
  assign RLAST   = r_last_q;

endmodule

// File: doc/axi4_burst_regbank.md
Name: axi4_burst_regbank

Overview:
- Parametrised AXI4 slave that fronts a word-addressed register bank.
- Supports full AXI4 bursts (FIXED/INCR/WRAP, AxLEN up to 255), byte strobes and per-beat RLAST/RRESP.
- Independent write and read FSMs; one outstanding transaction per direction.
- Sits behind the system interconnect as a memory-mapped register/scratch block.

Parameters:
DATA_WIDTH, 32, data bus width in bits (32/64/128)
ADDR_WIDTH, 32, byte address width
ID_WIDTH, 4, AxID/xID width
DEPTH, 256, register bank depth in DATA_WIDTH words (power of 2)
BASE_ADDR, 0, byte address of word 0; bank spans BASE_ADDR .. BASE_ADDR+DEPTH*(DATA_WIDTH/8)-1

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
AWVALID in 1; AWREADY out 1  AW handshake
WDATA/WSTRB/WLAST  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
WVALID in 1; WREADY out 1  W handshake
BID/BRESP  out  ID_WIDTH/2  write response
BVALID out 1; BREADY in 1  B handshake
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address
ARVALID in 1; ARREADY out 1  AR handshake
RID/RDATA/RRESP/RLAST  out  ID_WIDTH/DATA_WIDTH/2/1  read data
RVALID out 1; RREADY in 1  R handshake

Behaviour:
- Reset (ARESETn asynchronous, active-low; clock ACLK): all ready/valid outputs 0, BID/BRESP/RID/RDATA/RRESP/RLAST 0, FSMs to IDLE, bank cleared to 0. Reset mid-burst abandons the burst with no response.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1. On AW handshake: latch ID, addr, len, size, burst; beat counter=0; go to W_DATA (AWREADY=0).
  - W_DATA: WREADY=1. Each W handshake writes the bank at the current beat address, byte lanes gated by WSTRB. Beat address then advances per burst rules. After beat AWLEN, go to W_RESP.
  - W_RESP: BVALID=1 with latched BID. Hold until BREADY, then W_IDLE.
  - Minimum write turnaround: AW accept, 1 cycle per beat, BVALID the cycle after the last beat.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. On AR handshake: latch fields; RVALID asserts the next cycle with beat 0.
  - R_DATA: RDATA/RRESP/RLAST registered and held stable while RVALID && !RREADY. On each R handshake the next beat is presented the following cycle (no bubble under continuous RREADY).
  - RLAST=1 only on beat ARLEN. After the last handshake, go to R_IDLE.
- Burst address rules (byte address, step = 2^AxSIZE):
  - FIXED: address constant.
  - INCR: address += step.
  - WRAP: wrap boundary = aligned to step*(LEN+1). Legal LEN is 1, 3, 7 or 15; address wraps to the boundary when it reaches boundary+step*(LEN+1).
  - Reserved burst (2'b11), WRAP with an illegal LEN, or AxSIZE > log2(DATA_WIDTH/8): SLVERR. Writes suppressed for the whole burst; reads return RDATA=0. Beat count and RLAST still honour AxLEN.
- Word index = (beat addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
  - A beat outside the bank range is DECERR: write suppressed, RDATA=0.
  - Range is checked per beat, so an INCR burst may cross the top of the bank.
- BRESP priority across beats: DECERR > SLVERR > OKAY; worst value seen wins. RRESP is per beat.
- Narrow sizes: only lanes addressed by the beat are written (WSTRB ANDed with the size/offset lane mask). Reads return the full word.
- WLAST protocol error: WLAST=1 before beat AWLEN, or WLAST=0 on beat AWLEN, forces BRESP=SLVERR. Data is still written; beat count governs termination.
- Simultaneous read and write to the same word in the same cycle: the read returns the old value; the write lands at the edge.
- Write and read FSMs are fully concurrent. No exclusive access; EXOKAY is never returned.

Test Plan:
- Single write then read: AW addr 0x10, len 0, size 2, INCR, WDATA 0xDEADBEEF, WSTRB 0xF -> BRESP OKAY. AR same -> RDATA 0xDEADBEEF, RLAST=1, RRESP OKAY.
- INCR write len 3 at 0x20 with data 1,2,3,4; INCR read len 3 with RREADY toggling 1,0,1,0 -> data 1..4 held stable under stall, RLAST only on beat 4, no dropped or duplicated beats.
- WRAP read len 3, size 2, start 0x38 -> beat addresses 0x38, 0x3C, 0x30, 0x34. FIXED write len 3 to 0x40 -> only the last beat remains at 0x40.
- Strobes: word 0x50 preloaded 0xFFFFFFFF, write 0x12345678 with WSTRB 0x5 -> read returns 0xFF34FF78.
- Range/error: INCR len 1 starting at the last bank word -> beat 0 OKAY, beat 1 DECERR (RDATA 0), write BRESP DECERR. AWBURST=2'b11 -> SLVERR, bank unchanged.
- Reset mid-burst: assert ARESETn low during beat 2 of a len 7 read -> RVALID=0 immediately, bank 0. A new transaction after release completes normally.
